lpf_decim_sat: RTL and testbench

- Downstream stage of the FIR low-pass filter.
- Takes the full-precision filtered stream (DataIn/DataInVld), keeps one sample in every DecRatio, rounds and shifts it, saturates it to the output width, and buffers it in a small FIFO.
- Output is a ready/valid handshake to the next consumer.
- The FIR has no back-pressure, so this block absorbs output stalls and flags any loss.

---
 rtl/lpf_decim_sat.sv | 207 ++++++++++++++++++++
 tb/tb_lpf_decim_sat.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lpf_decim_sat.sv
// lpf_decim_sat: decimates the FIR output, rounds/shifts, saturates and buffers it behind a ready/valid port.
// Define LPF_DECIM_SAT_CNT_EN to build the saturation event counter on SatCnt; otherwise SatCnt is tied to 0.
module lpf_decim_sat #(
    parameter int DW    = 16,
    parameter int OW    = 8,
    parameter int SHIFT = 4,
    parameter int DECW  = 4,
    parameter int FD    = 4
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            Clear,
    input  logic [DECW-1:0] DecRatio,
    input  logic [DW-1:0]   DataIn,
    input  logic            DataInVld,
    output logic [OW-1:0]   DataOut,
    output logic            DataOutVld,
    input  logic            DataOutRdy,
    output logic            Ovf,
    output logic [15:0]     SatCnt
);
    localparam int AW     = (FD > 1) ? $clog2(FD) : 1;
    localparam int CW     = AW + 1;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [DW:0] RND     = (SHIFT > 0) ? ((DW+1)'(1) << RND_SH) : '0;
    localparam logic signed [DW:0] SAT_MAX = (DW+1)'((64'd1 << (OW - 1)) - 64'd1);
    localparam logic signed [DW:0] SAT_MIN = ~SAT_MAX;

    // ---------------- decimation ----------------
    logic [DECW-1:0] phase_reg;
    logic [DECW-1:0] ratio_reg;
    logic [DECW-1:0] ratio_eff;
    logic            keep;

    assign ratio_eff = (DecRatio == '0) ? DECW'(1) : DecRatio;
    assign keep      = DataInVld && (phase_reg == '0);

    // The ratio is sampled only at a group boundary so a mid-group change never shortens a group.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            phase_reg <= '0;
            ratio_reg <= DECW'(1);
        end else if (Clear) begin
            phase_reg <= '0;
            ratio_reg <= DECW'(1);
        end else if (DataInVld) begin
            if (phase_reg == '0) begin
                ratio_reg <= ratio_eff;
                phase_reg <= (ratio_eff == DECW'(1)) ? '0 : DECW'(1);
            end else if (phase_reg == ratio_reg - DECW'(1)) begin
                phase_reg <= '0;
            end else begin
                phase_reg <= phase_reg + DECW'(1);
            end
        end
    end

    // ---------------- stage 1: round and shift ----------------
    logic signed [DW:0] din_ext;
    logic signed [DW:0] rnd_sum;
    logic signed [DW:0] s1_reg;
    logic               s1_vld_reg;

    assign din_ext = {DataIn[DW-1], DataIn};
    assign rnd_sum = din_ext + RND;

    // ---------------- stage 2: saturate ----------------
    logic          s1_hi;
    logic          s1_lo;
    logic [OW-1:0] sat_val;
    logic [OW-1:0] s2_reg;
    logic          s2_vld_reg;

    assign s1_hi = (s1_reg > SAT_MAX);
    assign s1_lo = (s1_reg < SAT_MIN);

    always_comb begin
        sat_val = s1_reg[OW-1:0];
        if (s1_hi) begin
            sat_val = SAT_MAX[OW-1:0];
        end else if (s1_lo) begin
            sat_val = SAT_MIN[OW-1:0];
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            s1_reg     <= '0;
            s1_vld_reg <= 1'b0;
            s2_reg     <= '0;
            s2_vld_reg <= 1'b0;
        end else begin
            s1_reg <= rnd_sum >>> SHIFT;
            s2_reg <= sat_val;
            if (Clear) begin
                s1_vld_reg <= 1'b0;
                s2_vld_reg <= 1'b0;
            end else begin
                s1_vld_reg <= keep;
                s2_vld_reg <= s1_vld_reg;
            end
        end
    end

    // ---------------- output FIFO (show-ahead, registered head) ----------------
    logic [FD-1:0][OW-1:0] mem;
    logic [AW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         rd_ptr_reg;
    logic [AW-1:0]         rd_ptr_next;
    logic [CW-1:0]         count_reg;
    logic [CW-1:0]         remain;
    logic [CW-1:0]         count_next;
    logic [OW-1:0]         dout_reg;
    logic                  out_vld_reg;
    logic                  ovf_reg;
    logic                  pop;
    logic                  full;
    logic                  push;
    logic                  drop;
    logic [OW-1:0]         head_next;

    assign pop         = out_vld_reg && DataOutRdy;
    assign full        = (count_reg == CW'(FD));
    assign push        = s2_vld_reg && (!full || pop);
    assign drop        = s2_vld_reg && full && !pop;
    assign remain      = count_reg - CW'(pop);
    assign count_next  = remain + CW'(push);
    assign rd_ptr_next = rd_ptr_reg + AW'(pop);

    genvar gi;
    generate
        for (gi = 0; gi < FD; gi++) begin : g_slot
            logic [OW-1:0] slot_reg;
            always_ff @(posedge Clk) begin
                if (push && (wr_ptr_reg == AW'(gi))) begin
                    slot_reg <= s2_reg;
                end
            end
            assign mem[gi] = slot_reg;
        end
    endgenerate

    // When nothing else is stored, the incoming sample bypasses straight to the head for 3-cycle latency.
    always_comb begin
        head_next = dout_reg;
        if (remain != '0) begin
            head_next = mem[rd_ptr_next];
        end else if (push) begin
            head_next = s2_reg;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            dout_reg    <= '0;
            out_vld_reg <= 1'b0;
            ovf_reg     <= 1'b0;
        end else if (Clear) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            dout_reg    <= '0;
            out_vld_reg <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            wr_ptr_reg  <= wr_ptr_reg + AW'(push);
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            dout_reg    <= head_next;
            out_vld_reg <= (count_next != '0);
            if (drop) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    assign DataOut    = dout_reg;
    assign DataOutVld = out_vld_reg;
    assign Ovf        = ovf_reg;

    // ---------------- saturation counter ----------------
`ifdef LPF_DECIM_SAT_CNT_EN
    logic        s2_sat_reg;
    logic [15:0] sat_cnt_reg;

    // Counted at stage 2 so samples later dropped by a full FIFO are still included.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            s2_sat_reg  <= 1'b0;
            sat_cnt_reg <= '0;
        end else begin
            s2_sat_reg <= s1_hi || s1_lo;
            if (s2_vld_reg && s2_sat_reg && (sat_cnt_reg != 16'hFFFF)) begin
                sat_cnt_reg <= sat_cnt_reg + 16'd1;
            end
        end
    end

    assign SatCnt = sat_cnt_reg;
`else
    assign SatCnt = '0;
`endif

endmodule

// File: tb/tb_lpf_decim_sat.sv
// Directed self-checking bench for lpf_decim_sat: rounding, latency, saturation, decimation, FIFO overflow, Clear and Rst.
module tb_lpf_decim_sat;
    logic        Clk = 1'b0;
    logic        Rst;
    logic        Clear;
    logic [3:0]  DecRatio;
    logic [15:0] DataIn;
    logic        DataInVld;
    logic [7:0]  DataOut;
    logic        DataOutVld;
    logic        DataOutRdy;
    logic        Ovf;
    logic [15:0] SatCnt;

    int checks   = 0;
    int failures = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always #5 Clk = ~Clk;

    lpf_decim_sat dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Clear      (Clear),
        .DecRatio   (DecRatio),
        .DataIn     (DataIn),
        .DataInVld  (DataInVld),
        .DataOut    (DataOut),
        .DataOutVld (DataOutVld),
        .DataOutRdy (DataOutRdy),
        .Ovf        (Ovf),
        .SatCnt     (SatCnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Record every pop at the falling edge, then advance to just after the next rising edge.
    task automatic step();
        @(negedge Clk);
        if (DataOutVld && DataOutRdy) got_q.push_back(DataOut);
        @(posedge Clk);
        #1;
    endtask

    task automatic feed(input logic [15:0] d);
        DataIn    = d;
        DataInVld = 1'b1;
        step();
        DataInVld = 1'b0;
    endtask

    task automatic compare_queues(input string tag);
        check($sformatf("%s_count", tag), got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    initial begin
        Rst = 1'b1; Clear = 1'b0; DecRatio = 4'd1; DataIn = '0; DataInVld = 1'b0; DataOutRdy = 1'b1;
        #1;
        check("rst_vld", DataOutVld, 0);
        check("rst_dout", DataOut, 0);
        check("rst_ovf", Ovf, 0);
        check("rst_satcnt", SatCnt, 0);
        step(); step();
        Rst = 1'b0;
        step();

        // Rounding and 3-cycle latency
        feed(16'd24);
        step();
        check("lat2_vld", DataOutVld, 0);
        step();
        check("lat3_vld", DataOutVld, 1);
        check("round_pos", DataOut, 8'h02);
        step();
        check("empty_vld", DataOutVld, 0);
        check("empty_hold", DataOut, 8'h02);

        feed(16'hFFE8);
        step();
        check("neg_lat2_vld", DataOutVld, 0);
        step();
        check("neg_lat3_vld", DataOutVld, 1);
        check("round_neg", DataOut, 8'hFF);
        step();

        // Saturation
        got_q.delete();
        DataIn = 16'h7FFF; DataInVld = 1'b1; step();
        DataIn = 16'h8000; step();
        DataInVld = 1'b0;
        repeat (5) step();
        exp_q = '{8'h7F, 8'h80};
        compare_queues("sat");
`ifdef LPF_DECIM_SAT_CNT_EN
        check("satcnt", SatCnt, 2);
`else
        check("satcnt", SatCnt, 0);
`endif

        // Decimation by 3
        got_q.delete();
        DecRatio = 4'd3;
        for (int i = 0; i < 9; i++) begin
            DataIn = 16'(16 * (i + 1)); DataInVld = 1'b1; step();
        end
        DataInVld = 1'b0;
        repeat (5) step();
        exp_q = '{8'd1, 8'd4, 8'd7};
        compare_queues("dec3");

        // DecRatio 3 -> 0 after the first sample of a group
        got_q.delete();
        for (int i = 0; i < 6; i++) begin
            DecRatio = (i == 0) ? 4'd3 : 4'd0;
            DataIn = 16'(160 + 16 * i); DataInVld = 1'b1; step();
        end
        DataInVld = 1'b0;
        repeat (5) step();
        exp_q = '{8'd10, 8'd13, 8'd14, 8'd15};
        compare_queues("dec_change");

        // Overflow with consumer stalled
        got_q.delete();
        DecRatio = 4'd1; DataOutRdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            DataIn = 16'(16 * (i + 1)); DataInVld = 1'b1; step();
        end
        DataInVld = 1'b0;
        repeat (4) step();
        check("ovf_set", Ovf, 1);
        check("ovf_vld", DataOutVld, 1);
        check("ovf_stall_head", DataOut, 8'd1);
        DataOutRdy = 1'b1;
        repeat (6) step();
        exp_q = '{8'd1, 8'd2, 8'd3, 8'd4};
        compare_queues("ovf_drain");
        check("ovf_drain_vld", DataOutVld, 0);
        check("ovf_sticky", Ovf, 1);
        Clear = 1'b1; step(); Clear = 1'b0;
        check("ovf_cleared", Ovf, 0);

        // Full FIFO with simultaneous read and write
        DataOutRdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            DataIn = 16'(16 * (i + 1)); DataInVld = 1'b1; step();
        end
        DataInVld = 1'b0;
        repeat (3) step();
        check("full_vld", DataOutVld, 1);
        check("full_ovf", Ovf, 0);
        feed(16'd80);
        step();
        DataOutRdy = 1'b1;
        step();
        DataOutRdy = 1'b0;
        check("fullrw_ovf", Ovf, 0);
        check("fullrw_head", DataOut, 8'd2);
        got_q.delete();
        DataOutRdy = 1'b1;
        repeat (6) step();
        exp_q = '{8'd2, 8'd3, 8'd4, 8'd5};
        compare_queues("fullrw_drain");
        check("fullrw_empty", DataOutVld, 0);

        // Clear mid-stream: 2 queued plus a partial R=3 group
        DataOutRdy = 1'b0; DecRatio = 4'd1;
        feed(16'd16);
        feed(16'd32);
        DecRatio = 4'd3;
        feed(16'd48);
        repeat (3) step();
        check("clr_pre_vld", DataOutVld, 1);
        Clear = 1'b1; DataIn = 16'd64; DataInVld = 1'b1;
        step();
        Clear = 1'b0; DataInVld = 1'b0;
        check("clr_vld", DataOutVld, 0);
        check("clr_ovf", Ovf, 0);
        check("clr_dout", DataOut, 0);
        got_q.delete();
        DataOutRdy = 1'b1;
        feed(16'd16);
        repeat (5) step();
        exp_q = '{8'd1};
        compare_queues("clr_phase");

        // Asynchronous reset mid-stream
        Clear = 1'b1; step(); Clear = 1'b0;
        DataOutRdy = 1'b0; DecRatio = 4'd1;
        feed(16'd16);
        feed(16'd32);
        repeat (3) step();
        check("rst_pre_vld", DataOutVld, 1);
        Rst = 1'b1;
        #1;
        check("rst_async_vld", DataOutVld, 0);
        check("rst_async_dout", DataOut, 0);
        check("rst_async_satcnt", SatCnt, 0);
        step();
        Rst = 1'b0;
        repeat (3) step();
        check("rst_fifo_empty", DataOutVld, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
